// File: rtl/ir_loader_pkg.sv
// Shared definitions for the IR RAM program loader: FSM states, framing
// constants and the header word-count check.
package ir_loader_pkg;

  localparam int unsigned BYTES_PER_WORD         = 4;
  localparam int unsigned HDR_BYTES              = 2;
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 65535;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HDR_HI = 3'd1,
    ST_HDR_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_WRITE  = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERROR  = 3'd6
  } ir_state_e;

  // A word count is usable when it is non-zero and fits the memory.
  function automatic logic hdr_count_ok(input logic [15:0] n, input logic [16:0] cap);
    return (n != 16'd0) && ({1'b0, n} <= cap);
  endfunction

endpackage

// File: rtl/ir_word_assembler.sv
// Big-endian word assembler: shifts bytes in MSB first and flags the byte
// that completes a word. o_word is the word as it will be once the current
// byte is shifted in, so the caller can capture it on the completing cycle.
module ir_word_assembler
  import ir_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clear,
  input  logic        i_shift_en,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_word_full
);

  localparam int unsigned CNT_W = $clog2(BYTES_PER_WORD);

  logic [23:0]      r_shift;
  logic [CNT_W-1:0] r_cnt;

  // Byte shift register and wrapping byte counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift <= 24'd0;
      r_cnt   <= {CNT_W{1'b0}};
    end else if (i_clear) begin
      r_shift <= 24'd0;
      r_cnt   <= {CNT_W{1'b0}};
    end else if (i_shift_en) begin
      r_shift <= {r_shift[15:0], i_byte};
      r_cnt   <= r_cnt + CNT_W'(1);
    end
  end

  assign o_word      = {r_shift, i_byte};
  assign o_word_full = i_shift_en && (r_cnt == CNT_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/ir_ram_loader.sv
// Length-prefixed byte-stream loader for the instruction RAM. Holds the CPU
// while loading, writes words to consecutive addresses from 0 and reports
// sticky done/error status.
module ir_ram_loader
  import ir_loader_pkg::*;
#(
  parameter int unsigned ADDR_W         = 10,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int unsigned TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [16:0] CAPACITY = 17'd1 << ADDR_W;

  ir_state_e         r_state;
  ir_state_e         w_state_nxt;
  logic              r_rx_ready;
  logic              r_mem_we;
  logic              r_cpu_hold;
  logic              r_load_done;
  logic              r_load_err;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [ADDR_W:0]   r_words;
  logic [15:0]       r_count;
  logic [TMO_W-1:0]  r_tmo;

  logic              w_accept;
  logic              w_shift_en;
  logic              w_start_load;
  logic              w_tmo_expire;
  logic              w_last_word;
  logic              w_word_full;
  logic              w_in_rx_state;
  logic [15:0]       w_count_full;
  logic [ADDR_W:0]   w_words_inc;
  logic [DATA_W-1:0] w_word;

  assign w_accept      = rx_valid && r_rx_ready;
  assign w_in_rx_state = (r_state == ST_HDR_HI) || (r_state == ST_HDR_LO) || (r_state == ST_DATA);
  assign w_shift_en    = w_accept && (r_state == ST_DATA);
  assign w_count_full  = {r_count[15:8], rx_data};
  assign w_words_inc   = r_words + {{ADDR_W{1'b0}}, 1'b1};
  assign w_last_word   = (17'(w_words_inc) == 17'(r_count));
  // Idle cycle that would make the idle count reach the limit.
  assign w_tmo_expire  = !w_accept && (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1));

  ir_word_assembler u_asm (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clear     (w_start_load),
    .i_shift_en  (w_shift_en),
    .i_byte      (rx_data),
    .o_word      (w_word),
    .o_word_full (w_word_full)
  );

  // Next-state decode and load-start strobe.
  always_comb begin
    w_state_nxt  = r_state;
    w_start_load = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          w_state_nxt  = ST_HDR_HI;
          w_start_load = 1'b1;
        end else begin
          w_state_nxt = r_state;
        end
      end
      ST_HDR_HI: begin
        if (w_accept)          w_state_nxt = ST_HDR_LO;
        else if (w_tmo_expire) w_state_nxt = ST_ERROR;
        else                   w_state_nxt = r_state;
      end
      ST_HDR_LO: begin
        if (w_accept) begin
          if (hdr_count_ok(w_count_full, CAPACITY)) w_state_nxt = ST_DATA;
          else                                      w_state_nxt = ST_ERROR;
        end else if (w_tmo_expire) begin
          w_state_nxt = ST_ERROR;
        end else begin
          w_state_nxt = r_state;
        end
      end
      ST_DATA: begin
        if (w_word_full)       w_state_nxt = ST_WRITE;
        else if (w_tmo_expire) w_state_nxt = ST_ERROR;
        else                   w_state_nxt = r_state;
      end
      ST_WRITE: begin
        if (w_last_word) w_state_nxt = ST_DONE;
        else             w_state_nxt = ST_DATA;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Registered outputs decoded from the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_ready  <= 1'b0;
      r_mem_we    <= 1'b0;
      r_cpu_hold  <= 1'b0;
      r_load_done <= 1'b0;
      r_load_err  <= 1'b0;
      r_mem_addr  <= {ADDR_W{1'b0}};
      r_mem_wdata <= {DATA_W{1'b0}};
    end else begin
      r_rx_ready  <= (w_state_nxt == ST_HDR_HI) || (w_state_nxt == ST_HDR_LO) ||
                     (w_state_nxt == ST_DATA);
      r_mem_we    <= (w_state_nxt == ST_WRITE);
      r_cpu_hold  <= (w_state_nxt == ST_HDR_HI) || (w_state_nxt == ST_HDR_LO) ||
                     (w_state_nxt == ST_DATA) || (w_state_nxt == ST_WRITE);
      r_load_done <= (w_state_nxt == ST_DONE);
      r_load_err  <= (w_state_nxt == ST_ERROR);
      if (w_word_full) begin
        r_mem_addr  <= r_words[ADDR_W-1:0];
        r_mem_wdata <= w_word;
      end
    end
  end

  // Word count, header capture and saturating idle-cycle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_words <= {(ADDR_W+1){1'b0}};
      r_count <= 16'd0;
      r_tmo   <= {TMO_W{1'b0}};
    end else begin
      if (w_start_load)              r_words <= {(ADDR_W+1){1'b0}};
      else if (r_state == ST_WRITE)  r_words <= w_words_inc;

      if (w_accept && (r_state == ST_HDR_HI))      r_count[15:8] <= rx_data;
      else if (w_accept && (r_state == ST_HDR_LO)) r_count[7:0]  <= rx_data;

      if (w_start_load || w_accept)                          r_tmo <= {TMO_W{1'b0}};
      else if (w_in_rx_state && (r_tmo != {TMO_W{1'b1}}))    r_tmo <= r_tmo + TMO_W'(1);
    end
  end

  assign rx_ready     = r_rx_ready;
  assign mem_we       = r_mem_we;
  assign mem_addr     = r_mem_addr;
  assign mem_wdata    = r_mem_wdata;
  assign cpu_hold     = r_cpu_hold;
  assign load_done    = r_load_done;
  assign load_err     = r_load_err;
  assign words_loaded = r_words;

endmodule

// File: tb/tb_ir_ram_loader.sv
// Self-checking bench for ir_ram_loader: table-driven loads with random data
// and gaps, plus hand-written basic, timeout, capacity and reset sequences.
module tb_ir_ram_loader;

  localparam int ADDR_W = 10;
  localparam int TMO    = 16;

  typedef logic [7:0] byte_q_t[$];

  typedef struct {
    logic [15:0] n;
    int          nwords;
    int          extra;
    int          gap;
    bit          exp_done;
    bit          exp_err;
    int          exp_words;
  } vec_t;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_hold;
  logic              load_done;
  logic              load_err;
  logic [ADDR_W:0]   words_loaded;

  int checks = 0;
  int errors = 0;
  int rdy_viol = 0;
  string cur_tag = "init";

  logic [ADDR_W-1:0] act_addr[$];
  logic [31:0]       act_data[$];
  logic [31:0]       m_data[$];
  bit                m_done;
  bit                m_err;
  int                m_words;

  vec_t tbl[7];

  ir_ram_loader #(.ADDR_W(ADDR_W), .DATA_W(32), .TIMEOUT_CYCLES(TMO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .cpu_hold     (cpu_hold),
    .load_done    (load_done),
    .load_err     (load_err),
    .words_loaded (words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every RAM write; a write cycle must never offer rx_ready.
  always @(negedge clk) begin
    if (rst_n && mem_we) begin
      act_addr.push_back(mem_addr);
      act_data.push_back(mem_wdata);
      if (rx_ready) rdy_viol++;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s/%s: got %0h expected %0h", cur_tag, name, act, exp);
    end
  endtask

  // Reference: outcome of a load from the stream contents alone.
  function automatic void model(input byte_q_t s);
    int n;
    int full;
    m_data.delete();
    m_done  = 1'b0;
    m_err   = 1'b0;
    m_words = 0;
    if (s.size() < 2) begin
      m_err = 1'b1;
      return;
    end
    n = s[0] * 256 + s[1];
    if (n == 0 || n > (1 << ADDR_W)) begin
      m_err = 1'b1;
      return;
    end
    full = (s.size() - 2) / 4;
    if (full >= n) begin
      m_words = n;
      m_done  = 1'b1;
    end else begin
      m_words = full;
      m_err   = 1'b1;
    end
    for (int i = 0; i < m_words; i++)
      m_data.push_back({s[2+4*i], s[3+4*i], s[4+4*i], s[5+4*i]});
  endfunction

  // Offer one byte after a random idle gap; hold it until accepted.
  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int g;
    bit ok;
    g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
    repeat (g) begin @(posedge clk); #1; end
    rx_valid = 1'b1;
    rx_data  = b;
    ok = 1'b0;
    for (int w = 0; w < 20 && !ok; w++) begin
      @(negedge clk);
      if (rx_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    rx_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s/byte_accept: got no handshake expected accept of %0h", cur_tag, b);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Run a complete load of stream s and compare the outcome to the model.
  task automatic do_load(input byte_q_t s, input int gap);
    int w;
    int nchk;
    model(s);
    act_addr.delete();
    act_data.delete();
    pulse_start();
    chk("hold_on", 64'({cpu_hold, load_done, load_err}), 64'(3'b100));
    chk("words_clr", 64'(words_loaded), 64'd0);
    foreach (s[k]) send_byte(s[k], gap);
    if (m_err && s.size() == 2) chk("hdr_err_now", 64'(load_err), 64'd1);
    for (w = 0; w < 60 && !(load_done || load_err); w++) begin @(posedge clk); #1; end
    chk("done", 64'(load_done), 64'(m_done));
    chk("err", 64'(load_err), 64'(m_err));
    chk("words", 64'(words_loaded), 64'(m_words));
    chk("hold_off", 64'(cpu_hold), 64'd0);
    chk("n_writes", 64'(act_data.size()), 64'(m_data.size()));
    nchk = (act_data.size() < m_data.size()) ? act_data.size() : m_data.size();
    for (int i = 0; i < nchk; i++) begin
      chk("waddr", 64'(act_addr[i]), 64'(i));
      chk("wdata", 64'(act_data[i]), 64'(m_data[i]));
    end
  endtask

  initial begin
    byte_q_t s;
    logic [31:0] basic_exp[3];
    logic [31:0] tw;

    rst_n    = 1'b0;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'd0;

    tbl[0] = '{16'h0001, 1, 0, 0, 1'b1, 1'b0, 1};
    tbl[1] = '{16'h0000, 0, 0, 0, 1'b0, 1'b1, 0};
    tbl[2] = '{16'h0401, 0, 0, 0, 1'b0, 1'b1, 0};
    tbl[3] = '{16'h0005, 5, 0, 4, 1'b1, 1'b0, 5};
    tbl[4] = '{16'h0003, 2, 3, 2, 1'b0, 1'b1, 2};
    tbl[5] = '{16'h0008, 8, 0, 6, 1'b1, 1'b0, 8};
    tbl[6] = '{16'hFFFF, 0, 0, 0, 1'b0, 1'b1, 0};

    repeat (3) @(posedge clk);
    #1;
    cur_tag = "reset";
    chk("outs", 64'({rx_ready, mem_we, mem_addr, cpu_hold, load_done, load_err, words_loaded}), 64'd0);
    chk("wdata", 64'(mem_wdata), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic load with fixed bytes, then the same stream under backpressure.
    cur_tag = "basic";
    s = '{8'h00, 8'h03, 8'h20, 8'h11, 8'h00, 8'h01, 8'h08, 8'h00, 8'h00, 8'h05,
          8'h00, 8'h00, 8'h00, 8'h0C};
    basic_exp = '{32'h20110001, 32'h08000005, 32'h0000000C};
    do_load(s, 0);
    for (int i = 0; i < 3; i++)
      if (act_data.size() > i) chk("fixed_data", 64'(act_data[i]), 64'(basic_exp[i]));

    // Bytes offered after completion must not be taken.
    cur_tag = "done_idle";
    rx_valid = 1'b1;
    rx_data  = 8'hAA;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rdy_low", 64'(rx_ready), 64'd0);
      @(posedge clk); #1;
    end
    rx_valid = 1'b0;
    chk("no_write", 64'(act_data.size()), 64'd3);
    chk("still_done", 64'(load_done), 64'd1);

    cur_tag = "backpressure";
    do_load(s, 5);

    // Table-driven loads with random payload.
    for (int v = 0; v < 7; v++) begin
      cur_tag = $sformatf("tbl%0d", v);
      s.delete();
      s.push_back(tbl[v].n[15:8]);
      s.push_back(tbl[v].n[7:0]);
      for (int b = 0; b < tbl[v].nwords * 4 + tbl[v].extra; b++) s.push_back(8'($urandom));
      do_load(s, tbl[v].gap);
      chk("tbl_done", 64'(load_done), 64'(tbl[v].exp_done));
      chk("tbl_err", 64'(load_err), 64'(tbl[v].exp_err));
      chk("tbl_words", 64'(words_loaded), 64'(tbl[v].exp_words));
    end

    // Timeout: one full word, one stray byte, then silence.
    cur_tag = "timeout";
    act_addr.delete();
    act_data.delete();
    tw = $urandom;
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(tw[31:24], 0);
    send_byte(tw[23:16], 0);
    send_byte(tw[15:8], 0);
    send_byte(tw[7:0], 0);
    send_byte(8'h5A, 0);
    repeat (TMO - 1) begin @(posedge clk); #1; end
    chk("err_early", 64'(load_err), 64'd0);
    @(posedge clk); #1;
    chk("err_set", 64'(load_err), 64'd1);
    chk("words", 64'(words_loaded), 64'd1);
    chk("hold_off", 64'(cpu_hold), 64'd0);
    chk("n_writes", 64'(act_data.size()), 64'd1);
    if (act_data.size() > 0) begin
      chk("waddr", 64'(act_addr[0]), 64'd0);
      chk("wdata", 64'(act_data[0]), 64'(tw));
    end

    // Full capacity: data word equals its address.
    cur_tag = "full";
    s.delete();
    s.push_back(8'h04);
    s.push_back(8'h00);
    for (int i = 0; i < (1 << ADDR_W); i++) begin
      tw = 32'(i);
      s.push_back(tw[31:24]);
      s.push_back(tw[23:16]);
      s.push_back(tw[15:8]);
      s.push_back(tw[7:0]);
    end
    do_load(s, 0);
    chk("words_full", 64'(words_loaded), 64'd1024);
    if (act_data.size() == 1024) begin
      chk("last_addr", 64'(act_addr[1023]), 64'd1023);
      chk("last_data", 64'(act_data[1023]), 64'h3FF);
    end

    // Reset in the middle of a load, then a clean one-word load.
    cur_tag = "rst_mid";
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h03, 0);
    for (int i = 0; i < 6; i++) send_byte(8'(i + 1), 0);
    rst_n = 1'b0;
    #1;
    chk("outs", 64'({rx_ready, mem_we, mem_addr, cpu_hold, load_done, load_err, words_loaded}), 64'd0);
    chk("wdata", 64'(mem_wdata), 64'd0);
    act_addr.delete();
    act_data.delete();
    rx_valid = 1'b1;
    rx_data  = 8'h77;
    repeat (3) @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rst_n = 1'b1;
    chk("no_write_rst", 64'(act_data.size()), 64'd0);
    @(posedge clk); #1;
    cur_tag = "after_rst";
    s = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    do_load(s, 0);

    cur_tag = "global";
    chk("rdy_in_write", 64'(rdy_viol), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ir_ram_loader.md
Name: ir_ram_loader

Overview:
Byte-stream program loader that fills the instruction memory (10-bit word address, 32-bit word) instead of relying on a ROM image baked in at synthesis time.
It accepts a length-prefixed byte stream over a valid/ready handshake, assembles big-endian 32-bit words and writes them to consecutive IR RAM addresses from 0.
It holds the CPU in stall for the whole load and flags completion or error.
It sits between the host/UART byte receiver and the IR RAM write port, alongside the CPU's fetch port.

Parameters:
ADDR_W, 10, IR RAM word-address width; capacity = 2^ADDR_W words.
DATA_W, 32, instruction word width; fixed at 4 bytes per word.
TIMEOUT_CYCLES, 65535, maximum idle cycles between accepted bytes before abort.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  single-cycle pulse that begins a load.
rx_valid  in  1  byte available on rx_data.
rx_data  in  8  stream byte.
rx_ready  out  1  loader accepts a byte this cycle; transfer happens when rx_valid && rx_ready.
mem_we  out  1  IR RAM write strobe, one cycle per word.
mem_addr  out  ADDR_W  IR RAM word address.
mem_wdata  out  DATA_W  IR RAM write data.
cpu_hold  out  1  stalls the CPU and forces PC to 0 while asserted.
load_done  out  1  sticky; set when load completes successfully.
load_err  out  1  sticky; set on bad header or timeout.
words_loaded  out  ADDR_W+1  count of words written in the current/last load.

Behaviour:
- Reset (async, rst_n=0): state IDLE. rx_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=0, load_done=0, load_err=0, words_loaded=0. Reset mid-load abandons the load at once; no further writes.
- States: IDLE, HDR_HI, HDR_LO, DATA, WRITE, DONE, ERROR.
- IDLE: start -> HDR_HI. In the same edge, clear load_done, load_err and words_loaded, and set cpu_hold=1.
- HDR_HI / HDR_LO: rx_ready=1. Each accepted byte forms the 16-bit word count N (HI first).
- After HDR_LO, check N. N==0 or N>2^ADDR_W -> ERROR; otherwise -> DATA.
- DATA: rx_ready=1. Bytes shift in MSB first: word = {b0,b1,b2,b3}. The 2-bit byte counter wraps 3->0; on the 4th byte -> WRITE.
- WRITE: lasts exactly one cycle with rx_ready=0.
  - Drive mem_we=1, mem_addr=words_loaded[ADDR_W-1:0] and mem_wdata=the assembled word.
  - Then words_loaded increments.
  - Next state: -> DONE if words_loaded+1==N, else -> DATA.
- mem_we is 0 in every state except WRITE. mem_addr/mem_wdata hold their last values outside WRITE.
- DONE: cpu_hold=0, load_done=1, rx_ready=0. Bytes arriving here are not consumed.
- ERROR: cpu_hold=0, load_err=1, rx_ready=0. Memory contents are partial and undefined.
- Timeout: a counter runs in HDR_HI/HDR_LO/DATA, clears on every accepted byte and saturates. Reaching TIMEOUT_CYCLES -> ERROR.
- start in DONE or ERROR: restarts exactly as from IDLE. start in any other state is ignored.
- Full capacity: N=2^ADDR_W is legal. The last write is to address 2^ADDR_W-1, and words_loaded reads 2^ADDR_W (its extra bit exists for this).
- Byte/handshake rules:
  - A byte is consumed only on a cycle with rx_valid && rx_ready.
  - rx_valid with rx_ready=0 is held by the source, never dropped by the loader.
  - Throughput is 4 bytes per 5 cycles at best.

Decomposition:
- Shared package ir_loader_pkg holds:
  - state enum;
  - BYTES_PER_WORD=4;
  - HDR_BYTES=2;
  - default TIMEOUT_CYCLES.
- One natural sub-module, ir_word_assembler: byte shift register plus 2-bit byte counter, with inputs shift_en/clear and outputs word/word_full.
- The FSM, timeout counter and address counter stay in the top module.

Test Plan:
- Basic load: start; stream 00 03, 20 11 00 01, 08 00 00 05, 00 00 00 0C -> mem_we pulses 3 times; (addr,data) = (0,0x20110001),(1,0x08000005),(2,0x0000000C); load_done=1; cpu_hold falls; words_loaded=3.
- Backpressure/gaps: same stream with rx_valid toggled randomly, gaps < TIMEOUT_CYCLES -> identical writes; rx_ready=0 exactly on WRITE cycles; no byte lost or duplicated.
- Bad header: N=0x0000, and separately N=0x0401 -> load_err=1 after the 2nd byte, no mem_we, cpu_hold=0.
- Timeout (TIMEOUT_CYCLES=16): header 00 02, then 5 bytes, then silence -> one write at addr 0, load_err=1 after 16 idle cycles, words_loaded=1.
- Full capacity: N=0x0400 with data word = address -> 1024 writes, last at addr 1023 with data 0x000003FF, words_loaded=1024, load_done=1.
- Reset mid-load: assert rst_n=0 after 6 data bytes -> all outputs at reset values immediately; afterwards start + a 1-word stream writes to addr 0 correctly.
